// File: rtl/letter_pkg.sv
// Shared letter codes, seven-segment patterns (active-low, bit 0 = segment a)
// and the display mode type for the letter message path.
package letter_pkg;

   typedef enum logic {EDIT = 1'b0, SCROLL = 1'b1} mode_e;

   localparam logic [5:0]
      LTR_A = 6'd0,  LTR_B = 6'd1,  LTR_C = 6'd2,  LTR_D = 6'd3,  LTR_E = 6'd4,
      LTR_F = 6'd5,  LTR_G = 6'd6,  LTR_H = 6'd7,  LTR_I = 6'd8,  LTR_J = 6'd9,
      LTR_K = 6'd10, LTR_L = 6'd11, LTR_M = 6'd12, LTR_N = 6'd13, LTR_O = 6'd14,
      LTR_P = 6'd15, LTR_Q = 6'd16, LTR_R = 6'd17, LTR_S = 6'd18, LTR_T = 6'd19,
      LTR_U = 6'd20, LTR_V = 6'd21, LTR_W = 6'd22, LTR_X = 6'd23, LTR_Y = 6'd24,
      LTR_Z = 6'd25;

   // Codes above LTR_Z are not letters; this one is used internally for blank digits.
   localparam logic [5:0] CODE_BLANK = 6'h3F;

   localparam logic [6:0]
      SEG_A = ~7'h77, SEG_B = ~7'h7C, SEG_C = ~7'h39, SEG_D = ~7'h5E, SEG_E = ~7'h79,
      SEG_F = ~7'h71, SEG_G = ~7'h3D, SEG_H = ~7'h76, SEG_I = ~7'h30, SEG_J = ~7'h1E,
      SEG_K = ~7'h75, SEG_L = ~7'h38, SEG_M = ~7'h37, SEG_N = ~7'h54, SEG_O = ~7'h3F,
      SEG_P = ~7'h73, SEG_Q = ~7'h67, SEG_R = ~7'h50, SEG_S = ~7'h6D, SEG_T = ~7'h78,
      SEG_U = ~7'h3E, SEG_V = ~7'h1C, SEG_W = ~7'h2A, SEG_X = ~7'h64, SEG_Y = ~7'h6E,
      SEG_Z = ~7'h5B, SEG_BLANK = 7'h7F;

   function automatic logic is_letter(input logic [5:0] code);
      return code <= LTR_Z;
   endfunction

endpackage

// File: rtl/letter_message_controller_if.sv
// Board-side signals of the letter message controller: switches, keys and
// the four seven-segment digits.
interface letter_message_controller_if;
   logic [5:0] SW;
   logic [1:0] KEY;
   logic [6:0] HEX0;
   logic [6:0] HEX1;
   logic [6:0] HEX2;
   logic [6:0] HEX3;

   modport master (output SW, output KEY, input HEX0, input HEX1, input HEX2, input HEX3);
   modport slave  (input SW, input KEY, output HEX0, output HEX1, output HEX2, output HEX3);
endinterface

// File: rtl/letter_seg_decoder.sv
// Combinational letter code to active-low seven-segment lookup; non-letters blank.
module letter_seg_decoder
   import letter_pkg::*;
(
   input  logic [5:0] code_i,
   output logic [6:0] seg_o
);

   always_comb begin
      case (code_i)
         LTR_A: seg_o = SEG_A;   LTR_B: seg_o = SEG_B;   LTR_C: seg_o = SEG_C;
         LTR_D: seg_o = SEG_D;   LTR_E: seg_o = SEG_E;   LTR_F: seg_o = SEG_F;
         LTR_G: seg_o = SEG_G;   LTR_H: seg_o = SEG_H;   LTR_I: seg_o = SEG_I;
         LTR_J: seg_o = SEG_J;   LTR_K: seg_o = SEG_K;   LTR_L: seg_o = SEG_L;
         LTR_M: seg_o = SEG_M;   LTR_N: seg_o = SEG_N;   LTR_O: seg_o = SEG_O;
         LTR_P: seg_o = SEG_P;   LTR_Q: seg_o = SEG_Q;   LTR_R: seg_o = SEG_R;
         LTR_S: seg_o = SEG_S;   LTR_T: seg_o = SEG_T;   LTR_U: seg_o = SEG_U;
         LTR_V: seg_o = SEG_V;   LTR_W: seg_o = SEG_W;   LTR_X: seg_o = SEG_X;
         LTR_Y: seg_o = SEG_Y;   LTR_Z: seg_o = SEG_Z;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/letter_message_controller.sv
// Captures letters from SW on KEY[0] presses and shows them on HEX3..HEX0,
// either as the last four entered (EDIT) or as a rotating message (SCROLL).
//   state  | meaning
//   EDIT   | KEY[0] appends a letter, HEX0 shows the newest letter
//   SCROLL | message plus one blank slot rotates left every SCROLL_TICKS cycles
module letter_message_controller
   import letter_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int SCROLL_TICKS = 25_000_000
)(
   input  logic                        CLOCK_50,
   input  logic                        RESET,
   letter_message_controller_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(SCROLL_TICKS);

   logic [1:0]    key_s1_q, key_s2_q, key_prev_q, pulse_q;
   mode_e         mode_q;
   logic [CW-1:0] count_q, pos_q;
   logic [TW-1:0] tick_q;
   logic [5:0]    buf_q [DEPTH];
   logic          wr_en;
   logic [5:0]    code [4];
   logic [6:0]    seg [4];
   logic [6:0]    hex_q [4];
   logic [CW-1:0] idx, per;

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         key_s1_q   <= 2'b11;
         key_s2_q   <= 2'b11;
         key_prev_q <= 2'b11;
         pulse_q    <= 2'b00;
      end else begin
         key_s1_q   <= bus.KEY;
         key_s2_q   <= key_s1_q;
         key_prev_q <= key_s2_q;
         pulse_q    <= key_prev_q & ~key_s2_q;
      end
   end

   // A mode-toggle pulse always wins over a same-cycle letter pulse.
   assign wr_en = (mode_q == EDIT) && pulse_q[0] && !pulse_q[1] &&
                  is_letter(bus.SW) && (count_q < CW'(DEPTH));

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         mode_q  <= EDIT;
         count_q <= '0;
         pos_q   <= '0;
         tick_q  <= '0;
      end else begin
         case (mode_q)
            EDIT: begin
               if (pulse_q[1]) begin
                  if (count_q != '0) begin
                     mode_q <= SCROLL;
                     pos_q  <= '0;
                     tick_q <= '0;
                  end
               end else if (wr_en) begin
                  count_q <= count_q + 1'b1;
               end
            end
            SCROLL: begin
               if (pulse_q[1]) begin
                  mode_q  <= EDIT;
                  count_q <= '0;
                  pos_q   <= '0;
                  tick_q  <= '0;
               end else if (tick_q == TW'(SCROLL_TICKS - 1)) begin
                  tick_q <= '0;
                  pos_q  <= (pos_q == count_q) ? '0 : pos_q + 1'b1;
               end else begin
                  tick_q <= tick_q + 1'b1;
               end
            end
            default: mode_q <= EDIT;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (wr_en) buf_q[count_q[AW-1:0]] <= bus.SW;
   end

   // Scroll index is (p + k) mod (count+1); p <= count and k <= 3, so two
   // conditional subtractions always suffice.
   always_comb begin
      idx = '0;
      per = count_q + 1'b1;
      for (int d = 0; d < 4; d++) begin
         code[d] = CODE_BLANK;
         if (mode_q == EDIT) begin
            if (count_q > CW'(d)) begin
               idx     = count_q - CW'(d) - 1'b1;
               code[d] = buf_q[idx[AW-1:0]];
            end
         end else begin
            idx = pos_q + CW'(3 - d);
            if (idx >= per) idx = idx - per;
            if (idx >= per) idx = idx - per;
            if (idx != count_q) code[d] = buf_q[idx[AW-1:0]];
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_dig
      letter_seg_decoder u_dec (.code_i(code[g]), .seg_o(seg[g]));
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < 4; i++) hex_q[i] <= SEG_BLANK;
      end else begin
         for (int i = 0; i < 4; i++) hex_q[i] <= seg[i];
      end
   end

   assign bus.HEX0 = hex_q[0];
   assign bus.HEX1 = hex_q[1];
   assign bus.HEX2 = hex_q[2];
   assign bus.HEX3 = hex_q[3];

endmodule

// File: doc/letter_message_controller.md
# letter_message_controller

Sequences the switch-to-letter decode path into a four-digit message display. Each KEY[0] press captures one 6-bit letter code from SW into an 8-entry buffer. In EDIT mode the block shows the last four captured letters on HEX3..HEX0. KEY[1] switches to SCROLL mode, which rotates the whole message across the displays at a fixed rate. It sits between the board switches/keys and the four seven-segment displays and replaces direct per-press decoding.

## Interface
- DEPTH, 8: message buffer entries (letters); power of two, ≥4.
- SCROLL_TICKS, 25_000_000: CLOCK_50 cycles per scroll step (0.5 s); ≥2.
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous, active-high reset (one clock; asynchronous active-high reset).
- SW  in  6  letter code, SW[0] first bit; encoding per letter_pkg.
- KEY  in  2  active-low push buttons, asynchronous to clock; KEY[0] = enter letter, KEY[1] = mode toggle.
- HEX0..HEX3  out  7 each  active-low segments, bit 0 = segment a … bit 6 = segment g; all registered.

## Operation
- Button path:
  - Each KEY bit passes through a 2-FF synchronizer, then a registered falling-edge detector.
  - A press yields exactly one 1-cycle pulse regardless of hold time.
  - No debounce filter beyond this.
- State: mode ∈ {EDIT, SCROLL}, count (0..DEPTH), write pointer, scroll position p (0..count), tick counter.
- EDIT, KEY[0] pulse:
  - If SW is a valid letter code and count < DEPTH, store SW at buf[count] and increment count.
  - Invalid code or full buffer: ignore the press; no state change.
- EDIT, KEY[1] pulse:
  - count = 0: ignore.
  - Otherwise go to SCROLL with p = 0 and the tick counter cleared.
- SCROLL, KEY[0] pulse: ignore.
- SCROLL, KEY[1] pulse: go to EDIT, count = 0 (clears the message), p = 0.
- Simultaneous KEY[0] and KEY[1] pulses in one cycle: process only KEY[1]; drop KEY[0].
- EDIT display:
  - HEX0 = buf[count-1], HEX1 = buf[count-2], HEX2 = buf[count-3], HEX3 = buf[count-4].
  - Any nonexistent index shows blank (7'h7F).
- SCROLL display:
  - The message is the circular sequence buf[0..count-1] followed by one blank slot, period count+1.
  - HEX3 = element p, HEX2 = p+1, HEX1 = p+2, HEX0 = p+3, all indices mod (count+1).
  - When the tick counter reaches SCROLL_TICKS-1: clear it, and set p = p+1, wrapping to 0 after p = count.
- Decoding: letter code → segment pattern via the sub-module. Any code not in the letter table decodes to blank.

## Timing
- Reset (asynchronous):
  - mode = EDIT; count, p and tick counter = 0; synchronizer and edge registers = 1 (released).
  - HEX0..HEX3 = 7'h7F.
  - Buffer contents need not be reset.
- Press latency:
  - KEY low first sampled at edge N → pulse valid during cycle N+2 → buffer/state updated at edge N+3.
  - HEX outputs reflect the update at edge N+4.
- SW is sampled only in the pulse cycle. SW changes at any other time have no effect.
- Scroll step: p updates exactly every SCROLL_TICKS cycles; HEX follows one edge later.
- Mode switch: the HEX outputs show the new mode's display one edge after the mode register changes.
- RESET mid-scroll or mid-press: return immediately to the reset state; a pending pulse is lost.

## Structure
- Shared package letter_pkg:
  - 6-bit letter code constants (LTR_A … LTR_Z).
  - 7-bit segment constants (SEG_A … SEG_Z, SEG_BLANK = 7'h7F).
  - mode enum {EDIT, SCROLL}.
- Sub-module letter_seg_decoder: purely combinational code → segment lookup. Instantiate four copies, one per digit, each followed by an output register in the top level.

## Test plan
- Reset: assert RESET mid-run → HEX0..HEX3 = 7'h7F, mode EDIT, count 0.
- Enter LTR_A, LTR_B, LTR_C (hold SW stable, pulse KEY[0] low 10 cycles each) → HEX0 = SEG_C, HEX1 = SEG_B, HEX2 = SEG_A, HEX3 = SEG_BLANK; new letter visible 4 edges after KEY low sampled.
- Invalid code press → no change. Nine valid presses with DEPTH = 8 → count saturates at 8; ninth ignored; HEX0 shows the eighth letter.
- SCROLL_TICKS = 4, message A,B,C, KEY[1] → HEX3..HEX0 windows (A,B,C,_), (B,C,_,A), (C,_,A,B), (_,A,B,C), then (A,B,C,_) again, one step every 4 cycles.
- KEY[1] with count 0 → stays EDIT, all blank. KEY[0] and KEY[1] pressed in the same cycle during EDIT with count 2 → enters SCROLL, count stays 2.
- KEY[1] in SCROLL → EDIT with all digits blank. RESET asserted mid-scroll → outputs blank immediately, p = 0.
